// File: rtl/ascon_sub_layer_iter.sv
// Iterative ASCON substitution layer: applies the 5-bit S-box (or its inverse)
// to NB_SBOX of the 64 state columns per cycle, with valid/ready on both sides.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   ST_IDLE | ready for a new state; accepts on valid_i
//   ST_BUSY | substituting NB_SBOX columns per cycle, LSB column first
//   ST_DONE | result presented on state_o until ready_i
module ascon_sub_layer_iter #(
    parameter int NB_SBOX = 8
) (
    input  logic         clock_i,
    input  logic         reset_i,
    input  logic         valid_i,
    output logic         ready_o,
    input  logic         inv_i,
    input  logic [319:0] state_i,
    output logic         valid_o,
    input  logic         ready_i,
    output logic [319:0] state_o,
    output logic         busy_o
);

    localparam int NB_CYCLES = 64 / NB_SBOX;
    localparam logic [5:0] CNT_LAST = 6'(NB_CYCLES - 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    generate
        if (!(NB_SBOX == 1 || NB_SBOX == 2 || NB_SBOX == 4 || NB_SBOX == 8 ||
              NB_SBOX == 16 || NB_SBOX == 32 || NB_SBOX == 64)) begin : g_bad_nb_sbox
            $error("ascon_sub_layer_iter: NB_SBOX must be a power of two from 1 to 64");
        end
    endgenerate

    function automatic logic [4:0] sbox_fwd(input logic [4:0] x);
        logic [4:0] y;
        case (x)
            5'h00: y = 5'h04;  5'h01: y = 5'h0b;  5'h02: y = 5'h1f;  5'h03: y = 5'h14;
            5'h04: y = 5'h1a;  5'h05: y = 5'h15;  5'h06: y = 5'h09;  5'h07: y = 5'h02;
            5'h08: y = 5'h1b;  5'h09: y = 5'h05;  5'h0a: y = 5'h08;  5'h0b: y = 5'h12;
            5'h0c: y = 5'h1d;  5'h0d: y = 5'h03;  5'h0e: y = 5'h06;  5'h0f: y = 5'h1c;
            5'h10: y = 5'h1e;  5'h11: y = 5'h13;  5'h12: y = 5'h07;  5'h13: y = 5'h0e;
            5'h14: y = 5'h00;  5'h15: y = 5'h0d;  5'h16: y = 5'h11;  5'h17: y = 5'h18;
            5'h18: y = 5'h10;  5'h19: y = 5'h0c;  5'h1a: y = 5'h01;  5'h1b: y = 5'h19;
            5'h1c: y = 5'h16;  5'h1d: y = 5'h0a;  5'h1e: y = 5'h0f;  5'h1f: y = 5'h17;
            default: y = 5'h00;
        endcase
        return y;
    endfunction

    function automatic logic [4:0] sbox_inv(input logic [4:0] x);
        logic [4:0] y;
        case (x)
            5'h00: y = 5'h14;  5'h01: y = 5'h1a;  5'h02: y = 5'h07;  5'h03: y = 5'h0d;
            5'h04: y = 5'h00;  5'h05: y = 5'h09;  5'h06: y = 5'h0e;  5'h07: y = 5'h12;
            5'h08: y = 5'h0a;  5'h09: y = 5'h06;  5'h0a: y = 5'h1d;  5'h0b: y = 5'h01;
            5'h0c: y = 5'h19;  5'h0d: y = 5'h15;  5'h0e: y = 5'h13;  5'h0f: y = 5'h1e;
            5'h10: y = 5'h18;  5'h11: y = 5'h16;  5'h12: y = 5'h0b;  5'h13: y = 5'h11;
            5'h14: y = 5'h03;  5'h15: y = 5'h05;  5'h16: y = 5'h1c;  5'h17: y = 5'h1f;
            5'h18: y = 5'h17;  5'h19: y = 5'h1b;  5'h1a: y = 5'h04;  5'h1b: y = 5'h08;
            5'h1c: y = 5'h0f;  5'h1d: y = 5'h0c;  5'h1e: y = 5'h10;  5'h1f: y = 5'h02;
            default: y = 5'h00;
        endcase
        return y;
    endfunction

    logic [1:0]   r_fsm;
    logic [319:0] r_state;
    logic [5:0]   r_cnt;
    logic         r_inv;

    logic [63:0]  w_s0, w_s1, w_s2, w_s3, w_s4;
    logic [63:0]  w_n0, w_n1, w_n2, w_n3, w_n4;
    logic [5:0]   w_base;
    logic [5:0]   w_idx     [NB_SBOX];
    logic [4:0]   w_col_in  [NB_SBOX];
    logic [4:0]   w_col_out [NB_SBOX];
    logic [319:0] w_next;

    assign w_s0 = r_state[319:256];
    assign w_s1 = r_state[255:192];
    assign w_s2 = r_state[191:128];
    assign w_s3 = r_state[127:64];
    assign w_s4 = r_state[63:0];

    // First column of the current slice; with NB_SBOX=64 the slice is the whole state.
    assign w_base = 6'(int'(r_cnt) * NB_SBOX);

    generate
        for (genvar g = 0; g < NB_SBOX; g++) begin : g_sbox
            assign w_idx[g]     = w_base + 6'(g);
            assign w_col_in[g]  = {w_s0[w_idx[g]], w_s1[w_idx[g]], w_s2[w_idx[g]],
                                   w_s3[w_idx[g]], w_s4[w_idx[g]]};
            assign w_col_out[g] = r_inv ? sbox_inv(w_col_in[g]) : sbox_fwd(w_col_in[g]);
        end
    endgenerate

    always_comb begin
        w_n0 = w_s0;
        w_n1 = w_s1;
        w_n2 = w_s2;
        w_n3 = w_s3;
        w_n4 = w_s4;
        for (int k = 0; k < NB_SBOX; k++) begin
            w_n0[w_idx[k]] = w_col_out[k][4];
            w_n1[w_idx[k]] = w_col_out[k][3];
            w_n2[w_idx[k]] = w_col_out[k][2];
            w_n3[w_idx[k]] = w_col_out[k][1];
            w_n4[w_idx[k]] = w_col_out[k][0];
        end
        w_next = {w_n0, w_n1, w_n2, w_n3, w_n4};
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            r_fsm   <= ST_IDLE;
            r_state <= '0;
            r_cnt   <= '0;
            r_inv   <= 1'b0;
        end else begin
            case (r_fsm)
                ST_IDLE: begin
                    if (valid_i) begin
                        r_state <= state_i;
                        r_inv   <= inv_i;
                        r_cnt   <= '0;
                        r_fsm   <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    r_state <= w_next;
                    // Counter parks on the last slice so it never runs past the state.
                    if (r_cnt == CNT_LAST) begin
                        r_fsm <= ST_DONE;
                    end else begin
                        r_cnt <= r_cnt + 6'd1;
                    end
                end
                ST_DONE: begin
                    if (ready_i) begin
                        r_fsm <= ST_IDLE;
                    end
                end
                default: r_fsm <= ST_IDLE;
            endcase
        end
    end

    assign ready_o = (r_fsm == ST_IDLE) && !reset_i;
    assign valid_o = (r_fsm == ST_DONE);
    assign busy_o  = (r_fsm == ST_BUSY);
    assign state_o = r_state;

endmodule

// File: tb/tb_ascon_sub_layer_iter.sv
// Bench for ascon_sub_layer_iter: three instances (NB_SBOX = 1, 8, 64) checked every
// cycle against a whole-state latency model, plus directed literal expectations.
module tb_ascon_sub_layer_iter;

    localparam logic [4:0] FWD [32] = '{
        5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
        5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
        5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
        5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17};
    localparam logic [4:0] INV [32] = '{
        5'h14, 5'h1a, 5'h07, 5'h0d, 5'h00, 5'h09, 5'h0e, 5'h12,
        5'h0a, 5'h06, 5'h1d, 5'h01, 5'h19, 5'h15, 5'h13, 5'h1e,
        5'h18, 5'h16, 5'h0b, 5'h11, 5'h03, 5'h05, 5'h1c, 5'h1f,
        5'h17, 5'h1b, 5'h04, 5'h08, 5'h0f, 5'h0c, 5'h10, 5'h02};

    logic         clk = 1'b0;
    logic         rst;
    logic         valid_i [3];
    logic         inv_i   [3];
    logic         ready_i [3];
    logic [319:0] st_i    [3];
    logic         ready_o [3];
    logic         valid_o [3];
    logic         busy_o  [3];
    logic [319:0] st_o    [3];

    int n_total = 0;
    int n_pass  = 0;
    int cyc     = 0;
    bit tb_done = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    ascon_sub_layer_iter #(.NB_SBOX(1)) u_dut1 (
        .clock_i(clk), .reset_i(rst), .valid_i(valid_i[0]), .ready_o(ready_o[0]),
        .inv_i(inv_i[0]), .state_i(st_i[0]), .valid_o(valid_o[0]), .ready_i(ready_i[0]),
        .state_o(st_o[0]), .busy_o(busy_o[0]));
    ascon_sub_layer_iter #(.NB_SBOX(8)) u_dut8 (
        .clock_i(clk), .reset_i(rst), .valid_i(valid_i[1]), .ready_o(ready_o[1]),
        .inv_i(inv_i[1]), .state_i(st_i[1]), .valid_o(valid_o[1]), .ready_i(ready_i[1]),
        .state_o(st_o[1]), .busy_o(busy_o[1]));
    ascon_sub_layer_iter #(.NB_SBOX(64)) u_dut64 (
        .clock_i(clk), .reset_i(rst), .valid_i(valid_i[2]), .ready_o(ready_o[2]),
        .inv_i(inv_i[2]), .state_i(st_i[2]), .valid_o(valid_o[2]), .ready_i(ready_i[2]),
        .state_o(st_o[2]), .busy_o(busy_o[2]));

    function automatic int lat_of(input int k);
        return (k == 0) ? 64 : ((k == 1) ? 8 : 1);
    endfunction

    function automatic logic [4:0] get_col(input logic [319:0] s, input int j);
        return {s[256+j], s[192+j], s[128+j], s[64+j], s[j]};
    endfunction

    function automatic logic [319:0] sub_all(input logic [319:0] s, input logic inv);
        logic [319:0] r;
        logic [4:0]   v;
        r = '0;
        for (int j = 0; j < 64; j++) begin
            v = get_col(s, j);
            v = inv ? INV[v] : FWD[v];
            r[256+j] = v[4]; r[192+j] = v[3]; r[128+j] = v[2]; r[64+j] = v[1]; r[j] = v[0];
        end
        return r;
    endfunction

    function automatic logic [319:0] mk_cols();
        logic [319:0] s;
        logic [4:0]   v;
        s = '0;
        for (int j = 0; j < 64; j++) begin
            v = 5'(j);
            s[256+j] = v[4]; s[192+j] = v[3]; s[128+j] = v[2]; s[64+j] = v[1]; s[j] = v[0];
        end
        return s;
    endfunction

    task automatic chk(input string name, input logic [319:0] act, input logic [319:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Model: phase 0 idle, 1 processing (m_left cycles remaining), 2 result held.
    int           m_phase [3];
    int           m_left  [3];
    bit           m_zero  [3];
    logic [319:0] m_exp   [3];

    always @(posedge clk or posedge rst) begin
        for (int k = 0; k < 3; k++) begin
            if (rst) begin
                m_phase[k] = 0;
                m_zero[k]  = 1;
            end else begin
                case (m_phase[k])
                    0: if (valid_i[k]) begin
                        m_exp[k]   = sub_all(st_i[k], inv_i[k]);
                        m_left[k]  = lat_of(k);
                        m_phase[k] = 1;
                        m_zero[k]  = 0;
                    end
                    1: begin
                        m_left[k]--;
                        if (m_left[k] == 0) m_phase[k] = 2;
                    end
                    default: if (ready_i[k]) m_phase[k] = 0;
                endcase
            end
        end
    end

    always @(negedge clk) begin
        if (!tb_done) begin
            for (int k = 0; k < 3; k++) begin
                chk($sformatf("ready_o[%0d]", k), 320'(ready_o[k]), 320'(m_phase[k] == 0 && !rst));
                chk($sformatf("valid_o[%0d]", k), 320'(valid_o[k]), 320'(m_phase[k] == 2));
                chk($sformatf("busy_o[%0d]", k), 320'(busy_o[k]), 320'(m_phase[k] == 1));
                if (m_phase[k] == 2) chk($sformatf("state_o[%0d]", k), st_o[k], m_exp[k]);
                if (m_zero[k]) chk($sformatf("state_o_reset[%0d]", k), st_o[k], '0);
            end
        end
    end

    task automatic send(input int k, input logic [319:0] s, input logic inv);
        int t;
        t = 0;
        st_i[k] = s; inv_i[k] = inv; valid_i[k] = 1'b1;
        while (!ready_o[k] && t < 200) begin
            @(posedge clk); #1; t++;
        end
        @(posedge clk); #1;
        valid_i[k] = 1'b0;
        chk("send_wait", 320'(t < 200), 320'(1));
    endtask

    task automatic recv(input int k, input bit tog, output logic [319:0] r, output int lat);
        lat = 0;
        while (!valid_o[k] && lat < 200) begin
            if (tog) inv_i[k] = ~inv_i[k];
            @(posedge clk); #1; lat++;
        end
        r = st_o[k];
        ready_i[k] = 1'b1;
        @(posedge clk); #1;
        ready_i[k] = 1'b0;
        chk("ready_after_handshake", 320'(ready_o[k]), 320'(1));
    endtask

    logic [319:0] s, r, r2, held;
    int lat, t0, t1, t;

    initial begin
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            valid_i[k] = 0; inv_i[k] = 0; ready_i[k] = 0; st_i[k] = '0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            chk("ready_in_reset", 320'(ready_o[k]), 320'(0));
            chk("state_in_reset", st_o[k], '0);
        end
        rst = 1'b0;
        #1;
        chk("ready_after_reset", 320'(ready_o[1]), 320'(1));

        // Hand-derived model pins: S-box(0)=04 lights S2, inverse(0)=14 lights S0,S2.
        chk("model_fwd_zero", sub_all('0, 1'b0), {64'h0, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 64'h0});
        chk("model_inv_zero", sub_all('0, 1'b1),
            {64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 64'h0});

        send(1, '0, 1'b0);
        recv(1, 0, r, lat);
        chk("fwd_zero_latency", 320'(lat), 320'(8));
        chk("fwd_zero_result", r, {64'h0, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 64'h0});

        send(1, '0, 1'b1);
        recv(1, 0, r, lat);
        chk("inv_zero_result", r, {64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 64'h0});

        s = mk_cols();
        for (int k = 0; k < 3; k++) begin
            for (int m = 0; m < 2; m++) begin
                send(k, s, m[0]);
                recv(k, 0, r, lat);
                chk($sformatf("cols_latency[%0d]", k), 320'(lat), 320'(lat_of(k)));
                chk($sformatf("cols_result[%0d]", k), r, sub_all(s, m[0]));
                if (m == 0) begin
                    chk("col31_fwd", 320'(get_col(r, 31)), 320'(5'h17));
                    chk("col5_fwd", 320'(get_col(r, 5)), 320'(5'h15));
                    chk("col37_fwd", 320'(get_col(r, 37)), 320'(5'h15));
                end else begin
                    chk("col31_inv", 320'(get_col(r, 31)), 320'(5'h02));
                    chk("col5_inv", 320'(get_col(r, 5)), 320'(5'h09));
                    chk("col63_inv", 320'(get_col(r, 63)), 320'(5'h02));
                end
            end
        end

        for (int n = 0; n < 100; n++) begin
            for (int w = 0; w < 10; w++) s[w*32 +: 32] = $urandom;
            send(1, s, 1'b0);
            recv(1, 1, r, lat);
            send(1, r, 1'b1);
            recv(1, 1, r2, lat);
            chk("round_trip", r2, s);
        end

        // Backpressure: result must hold while a competing input is offered.
        s = mk_cols();
        send(1, s, 1'b0);
        t = 0;
        while (!valid_o[1] && t < 200) begin
            @(posedge clk); #1; t++;
        end
        held = st_o[1];
        valid_i[1] = 1'b1; st_i[1] = ~s; inv_i[1] = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            chk("bp_state_stable", st_o[1], held);
            chk("bp_valid_high", 320'(valid_o[1]), 320'(1));
            chk("bp_ready_low", 320'(ready_o[1]), 320'(0));
        end
        chk("bp_result", held, sub_all(s, 1'b0));
        valid_i[1] = 1'b0;
        ready_i[1] = 1'b1;
        @(posedge clk); #1;
        ready_i[1] = 1'b0;
        chk("bp_ready_next", 320'(ready_o[1]), 320'(1));

        // Throughput with both sides saturated: one state every 8 + 2 cycles.
        ready_i[1] = 1'b1; valid_i[1] = 1'b1; st_i[1] = s; inv_i[1] = 1'b0;
        t = 0;
        while (!valid_o[1] && t < 100) begin @(posedge clk); #1; t++; end
        t0 = cyc;
        while (valid_o[1] && t < 100) begin @(posedge clk); #1; t++; end
        while (!valid_o[1] && t < 100) begin @(posedge clk); #1; t++; end
        t1 = cyc;
        chk("throughput_period", 320'(t1 - t0), 320'(10));
        valid_i[1] = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        ready_i[1] = 1'b0;

        // Reset while the counter sits on slice 3.
        for (int w = 0; w < 10; w++) s[w*32 +: 32] = $urandom;
        send(1, s, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("rst_mid_valid", 320'(valid_o[1]), 320'(0));
        chk("rst_mid_busy", 320'(busy_o[1]), 320'(0));
        chk("rst_mid_state", st_o[1], '0);
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        chk("rst_mid_ready", 320'(ready_o[1]), 320'(1));
        send(1, s, 1'b1);
        recv(1, 0, r, lat);
        chk("after_rst_latency", 320'(lat), 320'(8));
        chk("after_rst_result", r, sub_all(s, 1'b1));

        repeat (2) @(posedge clk);
        tb_done = 1;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
